reg_writeback_unit: RTL

// Write-side driver for the 32x32 register file: accepts results from the ALU and the load/store unit,

---
 rtl/reg_writeback_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/reg_writeback_unit.sv
// Write-side driver for the register file C port: queues ALU and load results in order
// and issues at most one register write per cycle, with hazard mask and halt drain.
module reg_writeback_unit #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int NUM_REGS     = 32,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [REG_ADDR_LEN-1:0] alu_rd,
  input  logic [WIDTH-1:0]        alu_data,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [REG_ADDR_LEN-1:0] ld_rd,
  input  logic [WIDTH-1:0]        ld_data,
  input  logic [1:0]              ld_mode,
  input  logic                    halt_req,
  output logic [REG_ADDR_LEN-1:0] rf_regC_addr,
  output logic [WIDTH-1:0]        rf_dataC,
  output logic                    rf_w_en,
  output logic [1:0]              rf_w_mode,
  output logic [NUM_REGS-1:0]     pending_mask,
  output logic                    halt_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [REG_ADDR_LEN-1:0] ent_addr_r [DEPTH];
  logic [WIDTH-1:0]        ent_data_r [DEPTH];
  logic [1:0]              ent_mode_r [DEPTH];
  logic [DEPTH-1:0]        ent_valid_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;

  logic [REG_ADDR_LEN-1:0] rf_addr_r;
  logic [WIDTH-1:0]        rf_data_r;
  logic                    rf_w_en_r;
  logic [1:0]              rf_mode_r;
  logic                    halt_done_r;

  logic [CNT_W-1:0]        free_s;
  logic                    run_s;
  logic                    ld_push_s;
  logic                    alu_push_s;
  logic                    pop_s;
  logic [PTR_W-1:0]        alu_ptr_s;
  logic [NUM_REGS-1:0]     mask_s;

  // Narrow loads are zero-extended here so the file sees pre-masked data.
  function automatic logic [WIDTH-1:0] fmt_data(input logic [WIDTH-1:0] d, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    case (m)
      2'd1:    r = {{(WIDTH-16){1'b0}}, d[15:0]};
      2'd2:    r = {{(WIDTH-8){1'b0}}, d[7:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] fmt_mode(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      2'd1:    r = 2'd1;
      2'd2:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Handshake: free space excludes this cycle's pop; the load gets priority for a last slot.
  always_comb begin
    free_s     = CNT_W'(DEPTH) - count_r;
    run_s      = (state_r == ST_RUN);
    ld_ready   = run_s && (free_s >= CNT_W'(1));
    alu_ready  = run_s && ((free_s >= CNT_W'(2)) || ((free_s == CNT_W'(1)) && !ld_valid));
    ld_push_s  = ld_valid && ld_ready;
    alu_push_s = alu_valid && alu_ready;
    pop_s      = (count_r != CNT_W'(0));
    alu_ptr_s  = ld_push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
  end

  // FIFO pointers, occupancy and slot valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      ent_valid_r <= '0;
    end else begin
      if (pop_s) ent_valid_r[rd_ptr_r] <= 1'b0;
      if (ld_push_s) ent_valid_r[wr_ptr_r] <= 1'b1;
      if (alu_push_s) ent_valid_r[alu_ptr_s] <= 1'b1;
      wr_ptr_r <= wr_ptr_r + PTR_W'(ld_push_s) + PTR_W'(alu_push_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
      count_r  <= count_r + CNT_W'(ld_push_s) + CNT_W'(alu_push_s) - CNT_W'(pop_s);
    end
  end

  // FIFO payload storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (ld_push_s) begin
      ent_addr_r[wr_ptr_r] <= ld_rd;
      ent_data_r[wr_ptr_r] <= fmt_data(ld_data, ld_mode);
      ent_mode_r[wr_ptr_r] <= fmt_mode(ld_mode);
    end
    if (alu_push_s) begin
      ent_addr_r[alu_ptr_s] <= alu_rd;
      ent_data_r[alu_ptr_s] <= alu_data;
      ent_mode_r[alu_ptr_s] <= 2'd0;
    end
  end

  // Write port: R0 slots are consumed silently so the bus holds its previous values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_addr_r <= '0;
      rf_data_r <= '0;
      rf_mode_r <= 2'd0;
      rf_w_en_r <= 1'b0;
    end else if (pop_s && (ent_addr_r[rd_ptr_r] != '0)) begin
      rf_addr_r <= ent_addr_r[rd_ptr_r];
      rf_data_r <= ent_data_r[rd_ptr_r];
      rf_mode_r <= ent_mode_r[rd_ptr_r];
      rf_w_en_r <= 1'b1;
    end else begin
      rf_w_en_r <= 1'b0;
    end
  end

  // Pending destinations: queued entries plus the write currently on the port.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mask_s[ent_addr_r[i]] = mask_s[ent_addr_r[i]] |
                              (ent_valid_r[i] && (ent_addr_r[i] != '0));
    end
    mask_s[rf_addr_r] = mask_s[rf_addr_r] | rf_w_en_r;
  end

  // Run/drain/halt next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt_req) state_next_s = ST_DRAIN;
        else          state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if ((count_r == CNT_W'(0)) && !rf_w_en_r) state_next_s = ST_HALTED;
        else                                      state_next_s = ST_DRAIN;
      end
      ST_HALTED: state_next_s = ST_HALTED;
      default:   state_next_s = ST_RUN;
    endcase
  end

  // State register and registered halt indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      halt_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      halt_done_r <= (state_next_s == ST_HALTED);
    end
  end

  assign rf_regC_addr = rf_addr_r;
  assign rf_dataC     = rf_data_r;
  assign rf_w_en      = rf_w_en_r;
  assign rf_w_mode    = rf_mode_r;
  assign pending_mask = mask_s;
  assign halt_done    = halt_done_r;

endmodule
